// File: rtl/unidad_control_if.sv
// Instruction handshake and register-bank port bundle for unidad_control.
// The master side is the sequencer; the slave side is the bank/instruction source.
interface unidad_control_if #(
    parameter int DATA_W = 8
);
    logic [15:0]       instr;
    logic              instr_valid;
    logic              instr_ready;
    logic [2:0]        addr_rd1;
    logic [2:0]        addr_rd2;
    logic [DATA_W-1:0] dout1;
    logic [DATA_W-1:0] dout2;
    logic              we;
    logic [2:0]        addr_wr;
    logic [DATA_W-1:0] din;
    logic              flag_z;
    logic              flag_c;
    logic              done;
    logic              err;
    logic              halted;

    modport master (
        input  instr,
        input  instr_valid,
        output instr_ready,
        output addr_rd1,
        output addr_rd2,
        input  dout1,
        input  dout2,
        output we,
        output addr_wr,
        output din,
        output flag_z,
        output flag_c,
        output done,
        output err,
        output halted
    );

    modport slave (
        output instr,
        output instr_valid,
        input  instr_ready,
        input  addr_rd1,
        input  addr_rd2,
        output dout1,
        output dout2,
        input  we,
        input  addr_wr,
        input  din,
        input  flag_z,
        input  flag_c,
        input  done,
        input  err,
        input  halted
    );
endinterface

// File: rtl/unidad_control.sv
// Multicycle execute sequencer feeding an 8x8 register bank (IDLE->READ->EXEC->WB).
// Optional build macro HALT_ON_ILLEGAL_EN parks the FSM in HALT after an illegal opcode.
//
// state | meaning
// IDLE  | instr_ready high, waiting for instr_valid
// READ  | bank read addresses driven from latched instruction, operands captured
// EXEC  | ALU result and flags registered
// WB    | done pulse; write port active for opcodes 1-9, err for illegal
// HALT  | (HALT_ON_ILLEGAL_EN only) stuck until rst
module unidad_control #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    unidad_control_if.master  bus
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_READ = 3'd1;
    localparam logic [2:0] S_EXEC = 3'd2;
    localparam logic [2:0] S_WB   = 3'd3;
`ifdef HALT_ON_ILLEGAL_EN
    localparam logic [2:0] S_HALT = 3'd4;
`endif

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_LDI = 4'd8;
    localparam logic [3:0] OP_MOV = 4'd9;

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [15:0]       ir;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] result;
    logic              fz;
    logic              fc;

    logic [3:0]        op;
    logic              illegal;
    logic              writes_rd;
    logic              flag_upd;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W:0]   alu_full;
    logic              alu_c;
    logic [DATA_W-1:0] alu_res;

    assign op        = ir[15:12];
    assign illegal   = (op > OP_MOV);
    assign writes_rd = (op != OP_NOP) && !illegal;
    assign flag_upd  = (op >= OP_ADD) && (op <= OP_SHR);
    assign imm_ext   = DATA_W'(ir[7:0]);

    // One extra bit on the adder/subtractor gives carry and borrow for free.
    always_comb begin
        alu_full = '0;
        alu_c    = 1'b0;
        case (op)
            OP_ADD: begin
                alu_full = {1'b0, op_a} + {1'b0, op_b};
                alu_c    = alu_full[DATA_W];
            end
            OP_SUB: begin
                alu_full = {1'b0, op_a} - {1'b0, op_b};
                alu_c    = alu_full[DATA_W];
            end
            OP_AND: alu_full = {1'b0, op_a & op_b};
            OP_OR:  alu_full = {1'b0, op_a | op_b};
            OP_XOR: alu_full = {1'b0, op_a ^ op_b};
            OP_SHL: begin
                alu_full = {op_a, 1'b0};
                alu_c    = op_a[DATA_W-1];
            end
            OP_SHR: begin
                alu_full = {2'b00, op_a[DATA_W-1:1]};
                alu_c    = op_a[0];
            end
            OP_LDI: alu_full = {1'b0, imm_ext};
            OP_MOV: alu_full = {1'b0, op_a};
            default: alu_full = '0;
        endcase
    end

    assign alu_res = alu_full[DATA_W-1:0];

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (bus.instr_valid) state_nxt = S_READ;
            S_READ: state_nxt = S_EXEC;
            S_EXEC: state_nxt = S_WB;
`ifdef HALT_ON_ILLEGAL_EN
            S_WB:   state_nxt = illegal ? S_HALT : S_IDLE;
            S_HALT: state_nxt = S_HALT;
`else
            S_WB:   state_nxt = S_IDLE;
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            ir     <= '0;
            op_a   <= '0;
            op_b   <= '0;
            result <= '0;
            fz     <= 1'b0;
            fc     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && bus.instr_valid)
                ir <= bus.instr;
            if (state == S_READ) begin
                op_a <= bus.dout1;
                op_b <= bus.dout2;
            end
            if (state == S_EXEC) begin
                result <= alu_res;
                if (flag_upd) begin
                    fz <= (alu_res == '0);
                    fc <= alu_c;
                end
            end
        end
    end

    // Addresses follow the latched instruction; it clears to NOP so they reset to 0.
    assign bus.instr_ready = (state == S_IDLE);
    assign bus.addr_rd1    = ir[8:6];
    assign bus.addr_rd2    = ir[5:3];
    assign bus.addr_wr     = ir[11:9];
    assign bus.din         = result;
    assign bus.we          = (state == S_WB) && writes_rd;
    assign bus.done        = (state == S_WB);
    assign bus.err         = (state == S_WB) && illegal;
    assign bus.flag_z      = fz;
    assign bus.flag_c      = fc;
`ifdef HALT_ON_ILLEGAL_EN
    assign bus.halted      = (state == S_HALT);
`else
    assign bus.halted      = 1'b0;
`endif

endmodule

// File: tb/tb_unidad_control.sv
// Directed self-checking bench for unidad_control with a behavioural 8x8 register bank.
`timescale 1ns/1ps
module tb_unidad_control;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    unidad_control_if #(.DATA_W(8)) bus ();

    unidad_control #(.DATA_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] bank [8];
    assign bus.dout1 = bank[bus.addr_rd1];
    assign bus.dout2 = bank[bus.addr_rd2];
    always @(posedge clk) if (bus.we) bank[bus.addr_wr] <= bus.din;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one instruction and return at the negedge of its WB cycle.
    task automatic run(input logic [15:0] w);
        @(negedge clk);
        bus.instr = w;
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    logic [15:0] words [4];
    int acc [4];
    int idx, ready_bad, we_cnt, ready_cnt;

    initial begin
        bus.instr = 16'h0000;
        bus.instr_valid = 1'b0;
        words[0] = 16'h8205;  // LDI r1,05
        words[1] = 16'h1448;  // ADD r2,r1,r1
        words[2] = 16'h5688;  // XOR r3,r2,r1
        words[3] = 16'h68C0;  // SHL r4,r3

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", bus.instr_ready, 1);
        check("rst_we", bus.we, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_flags", {bus.flag_z, bus.flag_c}, 0);
        check("rst_halted", bus.halted, 0);
        check("rst_addrs", {bus.addr_rd1, bus.addr_rd2, bus.addr_wr}, 0);
        check("rst_din", bus.din, 0);
        rst = 1'b0;

        // LDI r1,0x0F with cycle-by-cycle latency check
        @(negedge clk);
        bus.instr = 16'h820F;
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
        @(negedge clk);
        check("ldi_read_we", {bus.we, bus.done, bus.instr_ready}, 0);
        @(negedge clk);
        check("ldi_exec_we", {bus.we, bus.done}, 0);
        @(negedge clk);
        check("ldi_wb_ctl", {bus.we, bus.done, bus.err}, 3'b110);
        check("ldi_wb_addr", bus.addr_wr, 1);
        check("ldi_wb_din", bus.din, 8'h0F);
        check("ldi_flags", {bus.flag_z, bus.flag_c}, 0);
        @(negedge clk);
        check("ldi_after", {bus.we, bus.done, bus.instr_ready}, 3'b001);
        check("ldi_bank", bank[1], 8'h0F);

        // ADD / SUB flags
        run(16'h82F0);
        run(16'h8420);
        run(16'h1650);
        check("add_din", bus.din, 8'h10);
        check("add_flags", {bus.flag_z, bus.flag_c}, 2'b01);
        check("add_wr", {bus.we, bus.addr_wr}, {1'b1, 3'd3});
        run(16'h2890);
        check("sub_din", bus.din, 8'h00);
        check("sub_flags", {bus.flag_z, bus.flag_c}, 2'b10);

        // LDI keeps flags; SHR sets z and c; MOV keeps them
        run(16'h8201);
        check("ldi_keep_flags", {bus.flag_z, bus.flag_c}, 2'b10);
        run(16'h7A40);
        check("shr_din", bus.din, 8'h00);
        check("shr_flags", {bus.flag_z, bus.flag_c}, 2'b11);
        run(16'h9D40);
        check("mov_din", {bus.we, bus.addr_wr, bus.din}, {1'b1, 3'd6, 8'h00});
        check("mov_flags", {bus.flag_z, bus.flag_c}, 2'b11);
        @(negedge clk);
        check("bank_r3", bank[3], 8'h10);
        check("bank_r4", bank[4], 8'h00);

        // instr_valid held high across four dependent instructions
        idx = 0; ready_bad = 0; we_cnt = 0; ready_cnt = 0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            bus.instr = (idx < 4) ? words[idx] : 16'h0000;
            bus.instr_valid = (idx < 4);
            if (k < 16 && (bus.instr_ready !== ((k % 4) == 0))) ready_bad++;
            if (k < 16 && bus.instr_ready) ready_cnt++;
            if (bus.we) we_cnt++;
            if (bus.instr_ready && idx < 4) begin
                acc[idx] = cyc;
                idx++;
            end
        end
        bus.instr_valid = 1'b0;
        check("bb_accepted", idx, 4);
        check("bb_gap1", acc[1] - acc[0], 4);
        check("bb_gap2", acc[2] - acc[1], 4);
        check("bb_gap3", acc[3] - acc[2], 4);
        check("bb_ready_pattern", ready_bad, 0);
        check("bb_ready_cnt", ready_cnt, 4);
        check("bb_writes", we_cnt, 4);
        check("bb_regs", {bank[1], bank[2], bank[3], bank[4]}, 32'h050A0F1E);
        check("bb_flags", {bus.flag_z, bus.flag_c}, 2'b00);

        // Illegal opcode, with z=1 set beforehand
        run(16'h2A90);
        check("pre_ill_flags", {bus.flag_z, bus.flag_c}, 2'b10);
        run(16'hF000);
        check("ill_wb", {bus.err, bus.done, bus.we}, 3'b110);
        check("ill_flags", {bus.flag_z, bus.flag_c}, 2'b10);
        @(negedge clk);
        check("ill_after", {bus.err, bus.done}, 0);
`ifdef HALT_ON_ILLEGAL_EN
        check("halt_state", {bus.halted, bus.instr_ready}, 2'b10);
        bus.instr = 16'h8E77;
        bus.instr_valid = 1'b1;
        we_cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.we || bus.err) we_cnt++;
        end
        bus.instr_valid = 1'b0;
        check("halt_stays", {bus.halted, bus.instr_ready}, 2'b10);
        check("halt_no_activity", we_cnt, 0);
`else
        check("no_halt", {bus.halted, bus.instr_ready}, 2'b01);
`endif
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("post_rst", {bus.halted, bus.instr_ready, bus.flag_z, bus.flag_c}, 4'b0100);

        // rst during EXEC discards the ADD to r7
        run(16'h8E55);
        run(16'h2A90);
        @(negedge clk);
        check("pre_abort_flags", {bus.flag_z, bus.flag_c}, 2'b10);
        bus.instr = 16'h1E50;
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ctl", {bus.we, bus.done, bus.instr_ready}, 3'b001);
        check("abort_flags", {bus.flag_z, bus.flag_c}, 2'b00);
        repeat (4) @(negedge clk);
        check("abort_r7", bank[7], 8'h55);

        // rst together with instr_valid in IDLE does not accept
        bus.instr = 16'h8E11;
        bus.instr_valid = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.instr_valid = 1'b0;
        check("rstvalid_ready", bus.instr_ready, 1);
        we_cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.we || bus.done) we_cnt++;
        end
        check("rstvalid_no_exec", we_cnt, 0);
        check("rstvalid_r7", bank[7], 8'h55);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/unidad_control.md
Name: unidad_control

Overview:
- Multicycle execute sequencer sitting directly upstream of the 8x8 register bank.
- Accepts one 16-bit instruction via a valid/ready handshake and drives the bank's read addresses, then captures the two read operands.
- Computes the result with an internal ALU and drives the bank's write port (we, addr_wr, din) for one writeback cycle.
- Also keeps registered zero/carry flags for downstream branch logic.

Parameters:
- DATA_W, 8, operand/result width; must equal the register bank data width; the 8-bit immediate is zero-extended when DATA_W > 8.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous, active-high; has priority over all other inputs.
- instr  input  16  instruction word; sampled only on acceptance.
- instr_valid  input  1  instruction present on instr.
- instr_ready  output  1  block can accept; high only in IDLE.
- addr_rd1  output  3  register bank read address 1 (rs1).
- addr_rd2  output  3  register bank read address 2 (rs2).
- dout1  input  DATA_W  register bank read data 1 (combinational from addr_rd1).
- dout2  input  DATA_W  register bank read data 2.
- we  output  1  register bank write enable.
- addr_wr  output  3  register bank write address (rd).
- din  output  DATA_W  register bank write data.
- flag_z  output  1  registered zero flag.
- flag_c  output  1  registered carry/borrow flag.
- done  output  1  one-cycle pulse in WB for every accepted instruction.
- err  output  1  one-cycle pulse in WB for an illegal opcode.
- halted  output  1  sticky halt indicator (see Optional Feature).

Behaviour:
- Instruction format:
  - op = instr[15:12], rd = instr[11:9], rs1 = instr[8:6], rs2 = instr[5:3], imm = instr[7:0].
- Opcodes:
  - 0 NOP; 1 ADD; 2 SUB (rs1-rs2); 3 AND; 4 OR; 5 XOR; 6 SHL (rs1<<1); 7 SHR (rs1>>1, logical).
  - 8 LDI (rd<=imm); 9 MOV (rd<=rs1); 10-15 illegal.
- Reset values: state=IDLE, instr_ready=1, we=0, done=0, err=0, flag_z=0, flag_c=0, halted=0.
  - addr_rd1, addr_rd2, addr_wr, din all 0.
  - Latched instruction register cleared to 0 (NOP).
- FSM states IDLE -> READ -> EXEC -> WB -> IDLE; no other transitions except rst.
- IDLE:
  - instr_ready=1.
  - On a rising edge with instr_valid=1, instr is latched and the FSM moves to READ.
  - instr_valid=0 keeps the FSM in IDLE.
- READ:
  - addr_rd1=rs1 and addr_rd2=rs2, driven from the latched instruction.
  - At the edge, dout1/dout2 are captured into op_a/op_b; FSM moves to EXEC.
- EXEC:
  - Result computed from op_a/op_b with DATA_W+1-bit arithmetic; registered at the edge; FSM moves to WB.
  - Flags are updated at this same edge, only for opcodes 1-7:
    - flag_z = (result == 0).
    - flag_c: ADD = carry out; SUB = borrow (op_a < op_b unsigned); SHL = op_a[DATA_W-1]; SHR = op_a[0]; AND/OR/XOR = 0.
  - NOP, LDI, MOV and illegal opcodes leave both flags unchanged.
- WB:
  - done=1.
  - Opcodes 1-9: we=1, addr_wr=rd, din=result.
  - NOP: we=0.
  - Illegal opcode: we=0, err=1.
  - FSM returns to IDLE at the next edge.
- In every state other than WB: we=0, done=0, err=0.
- Latency and throughput:
  - Acceptance at edge T0; we/done high during the cycle after edge T2; bank write lands at edge T3.
  - instr_ready is high again the cycle after T3.
  - Throughput is one instruction per 4 cycles.
- rd == rs1 or rd == rs2 is legal: operands are captured in READ, before the write.
- A back-to-back dependent instruction reads the updated value; no hazard logic is required.
- rst asserted in any state:
  - Next edge forces the reset values; the in-flight instruction is discarded with no write.
  - rst coinciding with instr_valid in IDLE does not accept the instruction.
- Arithmetic wraps modulo 2^DATA_W; din is always the low DATA_W bits.

Optional Feature:
- Macro: HALT_ON_ILLEGAL_EN.
- Defined:
  - An illegal opcode in WB moves the FSM to HALT instead of IDLE; halted=1 and instr_ready=0 until rst.
  - err pulses exactly once; no register is written while halted.
- Not defined:
  - No HALT state; halted is tied to 0; an illegal opcode only pulses err and the FSM returns to IDLE.

Test Plan:
- Reset then LDI r1,0x0F (instr=0x820F) -> we=1, addr_wr=1, din=0x0F exactly 3 cycles after the accept edge; done pulses once; flags stay 0.
- With r1=0xF0 and r2=0x20, ADD r3,r1,r2 -> din=0x10, flag_c=1, flag_z=0; then SUB r4,r2,r2 -> din=0x00, flag_z=1, flag_c=0.
- SHR r5,r1 with r1=0x01 -> din=0x00, flag_z=1, flag_c=1; then MOV r6,r5 -> din=0x00 with flags unchanged.
- Hold instr_valid=1 continuously with four instructions -> instr_ready high only in IDLE, each accepted exactly 4 cycles apart, no instruction dropped or duplicated.
- Opcode 0xF -> err=1 and done=1 for one cycle, we=0, flags unchanged; with HALT_ON_ILLEGAL_EN, halted=1 and instr_ready=0 until rst.
- Assert rst during EXEC of ADD r7,r1,r2 -> no write to r7, next cycle we=0, instr_ready=1, flags=0.
